// File: rtl/uart_rx_loader.sv
// UART receiver (8N1 by default) that hands each good word to a downstream load-enable register.
// A frame with a low stop bit raises frame_err instead of load, and D keeps its previous value.
module uart_rx_loader #(
  parameter int N            = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rx,
  output logic [N-1:0] D,
  output logic         load,
  output logic         frame_err,
  output logic         busy
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic          rx_meta;
  logic          rx_s;
  logic          rx_s_d;
  logic [1:0]    state;
  logic [BW-1:0] baud;
  logic [IW-1:0] idx;
  logic [N-1:0]  shreg;
  logic          baud_done;
  logic          half_done;
  logic          data_sample;

  assign half_done   = (baud == HALF_LAST);
  assign baud_done   = (baud == BIT_LAST);
  assign data_sample = (state == DATA) && baud_done;
  assign busy        = (state != IDLE);

  // Control path: synchronizer, edge detect, bit-period sequencing and strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      rx_s_d    <= 1'b1;
      state     <= IDLE;
      baud      <= '0;
      idx       <= '0;
      D         <= '0;
      load      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_s      <= rx_meta;
      rx_s_d    <= rx_s;
      load      <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          // A falling edge is required, so a held-low break line never retriggers.
          if (rx_s_d && !rx_s) begin
            baud  <= '0;
            state <= START;
          end
        end
        START: begin
          if (half_done) begin
            if (!rx_s) begin
              baud  <= '0;
              idx   <= '0;
              state <= DATA;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        DATA: begin
          if (baud_done) begin
            baud <= '0;
            if (idx == IDX_LAST) begin
              state <= STOP;
            end else begin
              idx <= idx + IW'(1);
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        default: begin
          if (baud_done) begin
            baud  <= '0;
            state <= IDLE;
            if (rx_s) begin
              D    <= shreg;
              load <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
      endcase
    end
  end

  // Data path: shift register is never reset and only reaches D through a good stop bit
  always_ff @(posedge clk) begin
    if (data_sample) begin
      shreg[idx] <= rx_s;
    end
  end

endmodule

// File: tb/tb_uart_rx_loader.sv
// Bench for uart_rx_loader: serial frames driven bit by bit and checked against a queue-based frame model.
module tb_uart_rx_loader;
  localparam int N   = 8;
  localparam int C   = 16;
  localparam int H   = C / 2;
  // two synchronizer stages plus the edge-detect cycle before t0, then the stop sample
  localparam int LAT = 3 + H + (N + 1) * C;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         rx = 1'b1;
  logic [N-1:0] D;
  logic         load;
  logic         frame_err;
  logic         busy;

  uart_rx_loader #(.N(N), .CLKS_PER_BIT(C)) dut (
    .clk(clk), .reset(reset), .rx(rx), .D(D),
    .load(load), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed strobes, collected once per cycle
  logic [N-1:0] words[$];
  int           load_cycs[$];
  int           n_err = 0;
  int           n_ovl = 0;
  always @(negedge clk) begin
    if (load) begin
      words.push_back(D);
      load_cycs.push_back(cyc);
    end
    if (frame_err) n_err++;
    if (load && frame_err) n_ovl++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  task automatic send_frame(input logic [N-1:0] d, input bit stop, output int sc);
    rx = 1'b0;
    sc = cyc;
    repeat (C) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      rx = d[i];
      repeat (C) @(negedge clk);
    end
    rx = stop;
    repeat (C) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n_chk++; if (D !== 8'h00) $display("FAIL reset_d got=%h exp=00", D); else n_pass++;
    n_chk++; if (load !== 1'b0) $display("FAIL reset_load got=%b exp=0", load); else n_pass++;
    n_chk++; if (frame_err !== 1'b0) $display("FAIL reset_ferr got=%b exp=0", frame_err); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    idle(5);
  endtask

  task automatic test_good_frame;
    int w0, e0, sc0, sc1;
    w0 = words.size();
    e0 = n_err;
    send_frame(8'hA5, 1'b1, sc0);
    send_frame(8'h3C, 1'b1, sc1);
    idle(40);
    n_chk++; if (words.size() - w0 !== 2) $display("FAIL good_load_count got=%0d exp=2", words.size() - w0); else n_pass++;
    if (words.size() - w0 >= 2) begin
      n_chk++; if (words[w0] !== 8'hA5) $display("FAIL good_word0 got=%h exp=a5", words[w0]); else n_pass++;
      n_chk++; if (load_cycs[w0] - sc0 !== LAT) $display("FAIL good_latency got=%0d exp=%0d", load_cycs[w0] - sc0, LAT); else n_pass++;
      n_chk++; if (words[w0+1] !== 8'h3C) $display("FAIL b2b_word1 got=%h exp=3c", words[w0+1]); else n_pass++;
    end
    n_chk++; if (n_err - e0 !== 0) $display("FAIL good_ferr got=%0d exp=0", n_err - e0); else n_pass++;
    n_chk++; if (D !== 8'h3C) $display("FAIL b2b_d_hold got=%h exp=3c", D); else n_pass++;
  endtask

  task automatic test_frame_error;
    int w0, e0, sc;
    w0 = words.size();
    e0 = n_err;
    send_frame(8'h5A, 1'b0, sc);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    n_chk++; if (busy !== 1'b0) $display("FAIL ferr_break_busy got=%b exp=0", busy); else n_pass++;
    idle(40);
    n_chk++; if (n_err - e0 !== 1) $display("FAIL ferr_pulse got=%0d exp=1", n_err - e0); else n_pass++;
    n_chk++; if (words.size() - w0 !== 0) $display("FAIL ferr_load got=%0d exp=0", words.size() - w0); else n_pass++;
    n_chk++; if (D !== 8'h3C) $display("FAIL ferr_d_hold got=%h exp=3c", D); else n_pass++;
  endtask

  task automatic test_start_glitch;
    int w0, e0;
    logic b10, b11;
    w0 = words.size();
    e0 = n_err;
    b10 = 1'b0;
    b11 = 1'b1;
    rx = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 4) rx = 1'b1;
      if (k == 3 + H - 1) b10 = busy;
      if (k == 3 + H) b11 = busy;
    end
    idle(20);
    n_chk++; if (b10 !== 1'b1) $display("FAIL glitch_busy_before got=%b exp=1", b10); else n_pass++;
    n_chk++; if (b11 !== 1'b0) $display("FAIL glitch_busy_drop got=%b exp=0", b11); else n_pass++;
    n_chk++; if (words.size() - w0 !== 0) $display("FAIL glitch_load got=%0d exp=0", words.size() - w0); else n_pass++;
    n_chk++; if (n_err - e0 !== 0) $display("FAIL glitch_ferr got=%0d exp=0", n_err - e0); else n_pass++;
  endtask

  task automatic test_reset_mid_frame;
    int w0, e0, sc;
    w0 = words.size();
    e0 = n_err;
    fork
      send_frame(8'hFF, 1'b1, sc);
      begin
        repeat (4 * C + 6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_chk++; if (D !== 8'h00) $display("FAIL rstmid_d got=%h exp=00", D); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL rstmid_busy got=%b exp=0", busy); else n_pass++;
        n_chk++; if (load !== 1'b0 || frame_err !== 1'b0) $display("FAIL rstmid_strobes got=%b%b exp=00", load, frame_err); else n_pass++;
      end
    join
    idle(20);
    n_chk++; if (words.size() - w0 !== 0 || n_err - e0 !== 0) $display("FAIL rstmid_no_strobe got=%0d/%0d exp=0/0", words.size() - w0, n_err - e0); else n_pass++;
    send_frame(8'h81, 1'b1, sc);
    idle(20);
    n_chk++; if (words.size() - w0 !== 1) $display("FAIL rstmid_next_count got=%0d exp=1", words.size() - w0); else n_pass++;
    n_chk++; if (D !== 8'h81) $display("FAIL rstmid_next_d got=%h exp=81", D); else n_pass++;
  endtask

  task automatic test_extremes;
    int w0, e0, sc;
    w0 = words.size();
    e0 = n_err;
    send_frame(8'h00, 1'b1, sc);
    send_frame(8'hFF, 1'b1, sc);
    idle(20);
    n_chk++; if (words.size() - w0 !== 2) $display("FAIL extreme_count got=%0d exp=2", words.size() - w0); else n_pass++;
    if (words.size() - w0 >= 2) begin
      n_chk++; if (words[w0] !== 8'h00) $display("FAIL extreme_zero got=%h exp=00", words[w0]); else n_pass++;
      n_chk++; if (words[w0+1] !== 8'hFF) $display("FAIL extreme_ones got=%h exp=ff", words[w0+1]); else n_pass++;
    end
    n_chk++; if (n_err - e0 !== 0) $display("FAIL extreme_ferr got=%0d exp=0", n_err - e0); else n_pass++;
  endtask

  task automatic test_random_frames;
    logic [N-1:0] exp_q[$];
    logic [N-1:0] exp_d;
    logic [N-1:0] d;
    int w0, e0, exp_err, sc;
    bit st;
    w0 = words.size();
    e0 = n_err;
    exp_err = 0;
    exp_d = D;
    for (int f = 0; f < 10; f++) begin
      d = N'($urandom);
      st = ($urandom_range(0, 3) != 0);
      send_frame(d, st, sc);
      if (st) begin
        exp_q.push_back(d);
        exp_d = d;
      end else begin
        exp_err++;
        idle(C);
      end
    end
    idle(30);
    n_chk++; if (words.size() - w0 !== exp_q.size()) $display("FAIL rand_count got=%0d exp=%0d", words.size() - w0, exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (w0 + i < words.size()) begin
        n_chk++; if (words[w0+i] !== exp_q[i]) $display("FAIL rand_word%0d got=%h exp=%h", i, words[w0+i], exp_q[i]); else n_pass++;
      end
    end
    n_chk++; if (n_err - e0 !== exp_err) $display("FAIL rand_ferr got=%0d exp=%0d", n_err - e0, exp_err); else n_pass++;
    n_chk++; if (D !== exp_d) $display("FAIL rand_final_d got=%h exp=%h", D, exp_d); else n_pass++;
    n_chk++; if (n_ovl !== 0) $display("FAIL strobe_overlap got=%0d exp=0", n_ovl); else n_pass++;
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_good_frame;
    test_frame_error;
    test_start_glitch;
    test_reset_mid_frame;
    test_extremes;
    test_random_frames;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
